// File: rtl/apb_lift_pkg.sv
// Shared types and register map for the lift-controller APB arbiter.
package apb_lift_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, REJECT} state_e;

  localparam logic [7:0] REG_CTRL  = 8'h00;
  localparam logic [7:0] REG_FLOOR = 8'h01;
  localparam logic [7:0] REG_CMD   = 8'h02;
  localparam logic [7:0] REG_CFG   = 8'h04;

  // Only the four mapped registers accept writes; reads are unrestricted.
  function automatic logic is_wr_legal(input logic [31:0] addr);
    return (addr == {24'h0, REG_CTRL})  || (addr == {24'h0, REG_FLOOR}) ||
           (addr == {24'h0, REG_CMD})   || (addr == {24'h0, REG_CFG});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IDX_W'(j)]) begin
        gnt             = '0;
        gnt[IDX_W'(j)]  = 1'b1;
        idx             = IDX_W'(j);
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_lift_bus_arbiter.sv
// Round-robin APB master sharing the lift-controller slave between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort transfers whose slave stalls for TIMEOUT ACCESS cycles.
module apb_lift_bus_arbiter
  import apb_lift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      PSELx_o,
  output logic                      PENABLE_o,
  output logic                      PWRITE_o,
  output logic [ADDR_W-1:0]         PADDR_o,
  output logic [DATA_W-1:0]         PWDATA_o,
  input  logic                      PREADY_i,
  input  logic [DATA_W-1:0]         PRDATA_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e state, nxt;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_REQ-1:0]             arb_gnt;
  logic [IDX_W-1:0]               arb_idx, ptr, cur;
  logic                           arb_any, accept, finish, fail, tmo_hit;
  logic [NUM_REQ-1:0]             done_q;
  logic                           err_q, pwrite_q;
  logic [ADDR_W-1:0]              paddr_q;
  logic [DATA_W-1:0]              pwdata_q, rdata_q;

  assign addr_v  = addr_i;
  assign wdata_v = wdata_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // tmo_cnt holds stalls already seen, so the TIMEOUT-th stall aborts.
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                        tmo_cnt <= '0;
    else if (accept)                     tmo_cnt <= '0;
    else if (state == ACCESS && !PREADY_i) tmo_cnt <= tmo_cnt + CNT_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    finish = 1'b0;
    fail   = 1'b0;
    case (state)
      IDLE: if (arb_any) begin
        accept = 1'b1;
        nxt    = (wr_i[arb_idx] && !is_wr_legal(32'(addr_v[arb_idx]))) ? REJECT : SETUP;
      end
      SETUP:  nxt = ACCESS;
      ACCESS: if (PREADY_i) begin
        nxt    = IDLE;
        finish = 1'b1;
      end else if (tmo_hit) begin
        nxt    = IDLE;
        finish = 1'b1;
        fail   = 1'b1;
      end
      REJECT: begin
        nxt    = IDLE;
        finish = 1'b1;
        fail   = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr      <= '0;
      cur      <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      if (accept) begin
        cur      <= arb_idx;
        pwrite_q <= wr_i[arb_idx];
        paddr_q  <= addr_v[arb_idx];
        pwdata_q <= wdata_v[arb_idx];
      end
      if (finish) begin
        done_q <= NUM_REQ'(1) << cur;
        err_q  <= fail;
        ptr    <= (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + IDX_W'(1);
        if (!fail && !pwrite_q) rdata_q <= PRDATA_i;
      end
    end
  end

  // Grant is combinational on req_i; masked so reset really forces it low.
  assign gnt_o     = (accept && PRESETn) ? arb_gnt : '0;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign PSELx_o   = (state == SETUP) || (state == ACCESS);
  assign PENABLE_o = (state == ACCESS);
  assign PWRITE_o  = pwrite_q;
  assign PADDR_o   = paddr_q;
  assign PWDATA_o  = pwdata_q;

endmodule

// File: tb/tb_apb_lift_bus_arbiter.sv
// Randomized bench for apb_lift_bus_arbiter against a transfer-level reference model.
module tb_apb_lift_bus_arbiter;

  localparam int NR   = 3;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TMO  = 4;
  localparam int NCYC = 3000;

  logic                  PCLK = 1'b0;
  logic                  PRESETn;
  logic [NR-1:0]         req, wr;
  logic [NR-1:0][AW-1:0] addr_v;
  logic [NR-1:0][DW-1:0] wdata_v;
  logic [NR-1:0]         gnt_o, done_o;
  logic                  err_o, PSELx_o, PENABLE_o, PWRITE_o, pready;
  logic [DW-1:0]         rdata_o, PWDATA_o, prdata;
  logic [AW-1:0]         PADDR_o;

  apb_lift_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_i(req), .wr_i(wr), .addr_i(addr_v),
    .wdata_i(wdata_v), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .PSELx_o(PSELx_o), .PENABLE_o(PENABLE_o),
    .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
    .PREADY_i(pready), .PRDATA_i(prdata)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one in-flight transfer, described by its age in cycles since grant.
  int            m_ptr, m_k, m_t, m_waits;
  bit            m_act, m_rej;
  logic          m_pwrite, m_err;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_rdata;
  logic [NR-1:0] m_done, pend, granted;

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      int j = (p + i) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_k = 0; m_t = 0; m_waits = 0; m_act = 0; m_rej = 0;
    m_pwrite = 0; m_err = 0; m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_done = '0;
  endtask

  task automatic end_xfer(input bit e);
    m_done = '0;
    m_done[m_k] = 1'b1;
    m_err = e;
    m_act = 0;
    m_ptr = (m_k + 1) % NR;
  endtask

  task automatic model_step();
    logic [NR-1:0] eg;
    bit epsel, epen;
    int w;
    eg = '0; epsel = 0; epen = 0;
    chk("done",   32'(done_o),   32'(m_done));
    chk("err",    32'(err_o),    32'(m_err));
    chk("rdata",  32'(rdata_o),  32'(m_rdata));
    chk("paddr",  32'(PADDR_o),  32'(m_paddr));
    chk("pwdata", 32'(PWDATA_o), 32'(m_pwdata));
    chk("pwrite", 32'(PWRITE_o), 32'(m_pwrite));
    m_done = '0;
    m_err  = 1'b0;
    if (!m_act) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        eg[w] = 1'b1; granted[w] = 1'b1;
        m_act = 1; m_k = w; m_t = 1; m_waits = 0;
        m_pwrite = wr[w]; m_paddr = addr_v[w]; m_pwdata = wdata_v[w];
        m_rej = wr[w] && !(addr_v[w] inside {8'h00, 8'h01, 8'h02, 8'h04});
      end
    end else if (m_rej) begin
      end_xfer(1);
    end else if (m_t == 1) begin
      epsel = 1; m_t = 2;
    end else begin
      epsel = 1; epen = 1;
      if (pready) begin
        if (!m_pwrite) m_rdata = prdata;
        end_xfer(0);
      end else begin
        m_waits++;
`ifdef APB_ARB_TIMEOUT_EN
        if (m_waits == TMO) end_xfer(1);
`endif
      end
    end
    chk("gnt",     32'(gnt_o),     32'(eg));
    chk("psel",    32'(PSELx_o),   32'(epsel));
    chk("penable", 32'(PENABLE_o), 32'(epen));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"},  32'(PSELx_o),   0);
    chk({tag, "_pen"},   32'(PENABLE_o), 0);
    chk({tag, "_pwr"},   32'(PWRITE_o),  0);
    chk({tag, "_paddr"}, 32'(PADDR_o),   0);
    chk({tag, "_pwd"},   32'(PWDATA_o),  0);
    chk({tag, "_done"},  32'(done_o),    0);
    chk({tag, "_err"},   32'(err_o),     0);
    chk({tag, "_rdata"}, 32'(rdata_o),   0);
    chk({tag, "_gnt"},   32'(gnt_o),     0);
  endtask

  initial begin
    int rdy_pct;
    bit rst_due, post_rst;
    PRESETn = 1'b0;
    req = '0; wr = '0; addr_v = '0; wdata_v = '0; pready = 1'b0; prdata = '0;
    pend = '0; granted = '0;
    rst_due = 0; post_rst = 0;
    model_reset();
    req = '1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_all_zero("rst");
    req = '0;
    PRESETn = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge PCLK);
      #1;
      if (cyc == 800 || cyc == 2100) rst_due = 1;
      for (int k = 0; k < NR; k++) begin
        if (done_o[k]) begin
          pend[k] = 0; granted[k] = 0; req[k] = 0;
        end else if (granted[k] && req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 0;
        end
        if (!pend[k] && (post_rst || $urandom_range(0, 2) == 0)) begin
          pend[k] = 1; req[k] = 1;
          wr[k] = 1'($urandom_range(0, 1));
          addr_v[k] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
          wdata_v[k] = 8'($urandom);
        end
      end
      post_rst = 0;
      rdy_pct = ((cyc / 500) % 3 == 0) ? 2 : (((cyc / 500) % 3 == 1) ? 5 : 9);
      pready = ($urandom_range(0, 9) < rdy_pct);
      prdata = 8'($urandom);

      if (rst_due && m_act && !m_rej && m_t == 2) begin
        rst_due = 0;
        #2 PRESETn = 1'b0;
        #1 check_all_zero("midrst");
        req = '0; pend = '0; granted = '0;
        model_reset();
        @(negedge PCLK);
        PRESETn = 1'b1;
        post_rst = 1;
        continue;
      end

      @(negedge PCLK);
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_lift_bus_arbiter.md
Name: apb_lift_bus_arbiter

Overview:
- APB master that shares the lift-controller APB slave (register map 0x00/0x01/0x02/0x04) between NUM_REQ requesters, e.g. host CPU bridge and lift sequencer.
- Arbitrates round-robin, drives the APB SETUP/ACCESS phases, waits on PREADY, returns read data and completion per requester.
- Sits between the requester logic and the slave's PSELx/PENABLE/PWRITE/PADDR port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting PREADY (used only with the optional feature)

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request, held until done_o for that requester
- wr_i  in  NUM_REQ  per-requester direction, 1 = write
- addr_i  in  NUM_REQ*ADDR_W  packed per-requester address; requester k at bits [k*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_REQ*DATA_W  packed per-requester write data
- gnt_o  out  NUM_REQ  one-hot; high during the cycle a request is accepted (IDLE->SETUP)
- done_o  out  NUM_REQ  one-hot 1-cycle completion pulse
- err_o  out  1  1-cycle pulse coincident with done_o on a rejected or aborted transfer
- rdata_o  out  DATA_W  read data, valid with done_o on a read
- PSELx_o  out  1  APB select
- PENABLE_o  out  1  APB enable
- PWRITE_o  out  1  APB direction
- PADDR_o  out  ADDR_W  APB address
- PWDATA_o  out  DATA_W  APB write data
- PREADY_i  in  1  slave ready
- PRDATA_i  in  DATA_W  slave read data

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0.
- FSM states and transitions:
  - IDLE: if any req_i is set, pick the first set bit searching from ptr upward with wrap. Assert gnt_o[k]. Latch wr, addr and wdata of requester k. Go to SETUP, or to REJECT on an illegal write.
  - SETUP: PSELx_o = 1, PENABLE_o = 0, address, direction and data driven from the latch. Always go to ACCESS next cycle.
  - ACCESS: PSELx_o = 1, PENABLE_o = 1.
    - PREADY_i = 0: stay in ACCESS, all APB outputs held stable.
    - PREADY_i = 1: capture PRDATA_i into rdata_o on reads, pulse done_o[k] next cycle, ptr = k+1 mod NUM_REQ, go to IDLE.
  - REJECT: illegal write, i.e. address not in {0x00, 0x01, 0x02, 0x04}.
    - No bus cycle is issued.
    - done_o[k] and err_o pulse; ptr advances; go to IDLE.
  - Reads to any address are legal.
- Timing:
  - Minimum transfer: grant at cycle 0, SETUP cycle 1, ACCESS cycle 2 with PREADY = 1, done_o cycle 3.
  - Back-to-back grant is possible the cycle done_o is asserted (IDLE evaluated in the same cycle done_o is registered out).
  - Between transfers PSELx_o and PENABLE_o return to 0 for at least one cycle.
- Data outputs:
  - PADDR_o, PWDATA_o and PWRITE_o keep their last values in IDLE, with PSELx_o = 0.
  - rdata_o holds its last read value until the next read completes.
- Requester behaviour: dropping req_i after grant does not cancel the transfer.
- Simultaneous requests: only one grant per IDLE cycle; the others wait.
- Fairness: each waiting requester is served within NUM_REQ transfers.
- Reset mid-transfer: all outputs go to 0 immediately (asynchronous). No done_o is issued for the lost transfer.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) counts ACCESS cycles with PREADY_i = 0.
  - When the count reaches TIMEOUT, the transfer is aborted: PSELx_o and PENABLE_o drop, done_o[k] and err_o pulse, rdata_o is unchanged, ptr advances, go to IDLE.
  - The counter clears on entry to SETUP.
- Not defined: ACCESS waits indefinitely; no counter logic is present.

Decomposition:
- Package apb_lift_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, REJECT}
  - localparams REG_CTRL = 8'h00, REG_FLOOR = 8'h01, REG_CMD = 8'h02, REG_CFG = 8'h04
  - function is_wr_legal(addr)
- One sub-module is natural: rr_arbiter (req vector + ptr -> one-hot grant + index), combinational with pointer in the parent.

Test Plan:
- Single write: req_i = 01, wr = 1, addr = 0x01, wdata = 0xA5, PREADY tied 1 -> PSELx_o high cycles 1-2, PENABLE_o cycle 2, PADDR_o = 0x01, PWDATA_o = 0xA5, done_o = 01 at cycle 3, err_o = 0.
- Read with wait states: requester 1 reads 0x04, PREADY low 3 ACCESS cycles, PRDATA = 0x3C -> APB outputs stable during wait, rdata_o = 0x3C with done_o = 10 at cycle 6.
- Contention: req_i = 11 continuously, PREADY = 1 -> grants alternate 01, 10, 01, 10; PSELx_o low one cycle between transfers.
- Illegal write: wr = 1, addr = 0x03 -> PSELx_o never asserted, done_o and err_o pulse 2 cycles after request.
- Reset mid-ACCESS: PRESETn low while PENABLE_o = 1 -> all outputs 0 the same cycle, no done_o, next request after reset granted to requester 0.
- With APB_ARB_TIMEOUT_EN, TIMEOUT = 4, PREADY held 0 -> abort after 4 ACCESS cycles, err_o = 1, done_o pulses, PSELx_o = 0.
